vend_ctrl_param: RTL
====================

// Module: vend_ctrl_param
// PURPOSE
//  Next-generation vending controller: N-item catalogue with parameter price table, quantity 1..MAX_QTY,
//  edge-detected coin inputs, inactivity timeout refund, vend handshake to the dispenser, and
//  sequential coin-by-coin change payout. Sits between front-panel inputs and dispenser/coin-return
//  actuators. Seven-segment driving is done downstream from the BCD outputs.
// PARAMETERS
//  N_ITEMS    4                        number of selectable items (1..8)
//  MAX_QTY    3                        max quantity per purchase (1..7)
//  VAL_W      12                       width of all money values, in cents
//  PRICES     {12'd120,12'd100,12'd80,12'd50}  packed N_ITEMS*VAL_W price table; item 0 in the LSBs; multiples of 5
//  TIMEOUT    1000                     idle cycles in COLLECT before auto-refund; 0 disables the timeout
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous, active-high reset
//  item_sel     in   N_ITEMS    one-hot item request; sampled only in IDLE
//  qty_sel      in   MAX_QTY    one-hot quantity (bit k => k+1); sampled in COLLECT
//  coin_dime    in   1          level from coin acceptor; +10 on rising edge
//  coin_quarter in   1          +25 on rising edge
//  coin_dollar  in   1          +100 on rising edge
//  cancel_n     in   1          active-low cancel
//  continue_n   in   1          active-low continue; leaves DONE
//  vend_ack     in   1          dispenser accepted the vend request
//  item_led     out  N_ITEMS    one-hot selected item
//  qty_out      out  MAX_QTY    one-hot current quantity
//  collected    out  VAL_W      money inserted in this transaction
//  change_rem   out  VAL_W      change still owed
//  vend_valid   out  1          vend request
//  vend_item    out  3          item index
//  vend_qty     out  3          quantity (1..MAX_QTY)
//  chg_dollar / chg_quarter / chg_dime / chg_nickel   out  1 each   one-cycle payout pulses
//  busy         out  1          1 in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 except qty_out=1 (qty 1). Edge-detect history is loaded with the
//   current coin levels, so a coin held through reset is not counted.
//  State register: state <= nxt every cycle. Registered outputs lag the state by 0 cycles.
//  IDLE: collected=0, change_rem=0, qty=1. Exactly one item_sel bit set -> COLLECT and latch item_led.
//   Zero bits or more than one bit set: stay in IDLE.
//  COLLECT:
//   - Coin edges add to collected. If edges coincide, priority is dollar > quarter > dime; a losing
//     coin is not counted and is returned on the next cycle via the payout path.
//   - Valid one-hot qty_sel updates qty. Invalid codes and 0 leave qty unchanged.
//   - cost = price*qty, computed at VAL_W+3 bits. Checked the cycle after any update:
//     collected >= cost -> change_rem = collected - cost, go to VEND.
//   - cancel_n=0, or the idle counter reaching TIMEOUT: change_rem = collected, go to CHANGE if
//     collected != 0, else IDLE.
//   - The idle counter clears on any coin or qty edge.
//   - collected saturates at 2^VAL_W-1.
//  VEND: vend_valid=1, with vend_item and vend_qty stable until the cycle vend_ack=1 is seen. Then
//   vend_valid=0 next cycle and go to CHANGE. cancel_n is ignored. Coin edges are added to change_rem
//   (refunded).
//  CHANGE: one pulse per cycle, greedy. change_rem>=100 -> dollar; >=25 -> quarter; >=10 -> dime;
//   >=5 -> nickel; subtract the coin value in the same cycle. Leftover <5 is forced to 0.
//   change_rem==0 -> DONE (if a vend occurred) or IDLE (cancel/timeout).
//  DONE: holds item_led/qty_out; collected is frozen. continue_n=0 -> IDLE, clear all.
//  rst mid-operation: everything returns to reset values the next cycle. An owed refund is lost;
//   this is documented.
// STRUCTURE
//  vend_pkg: state enum (IDLE, COLLECT, VEND, CHANGE, DONE), coin values COIN_DIME=10,
//   COIN_QUARTER=25, COIN_DOLLAR=100, COIN_NICKEL=5, and the onehot2idx function.
//  Sub-module vend_coin_edge: 3-bit rising-edge detector with priority encoding, instantiated once.
//  Price mux, cost multiply and payout logic stay in the top module.
// TESTING
//  1. Item 0 (50c), qty 1, insert quarter,quarter -> VEND with vend_item=0, vend_qty=1; ack ->
//     change_rem=0 -> DONE.
//  2. Item 1 (80c), qty 1, insert dollar -> change_rem=20 -> two chg_dime pulses in consecutive cycles -> DONE.
//  3. Item 2 (100c), qty_sel=3'b100, insert 3 dollars -> collected=300, vend_qty=3, no change pulses.
//  4. Item 3, insert dime,quarter, cancel_n=0 -> no vend_valid; refund pulses quarter then dime -> IDLE.
//  5. TIMEOUT=8, item 0, insert dime, idle 8 cycles -> one chg_dime -> IDLE. Repeat with a coin at
//     cycle 6 -> counter restarts.
//  6. Dime and quarter edges in the same cycle -> collected+=25, dime returned next cycle. rst
//     mid-VEND -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared states, coin values and index helper for the vending controller
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VEND    = 3'd2,
    CHANGE  = 3'd3,
    DONE    = 3'd4
  } vend_state_t;

  localparam int COIN_NICKEL  = 5;
  localparam int COIN_DIME    = 10;
  localparam int COIN_QUARTER = 25;
  localparam int COIN_DOLLAR  = 100;

  // Index of the set bit in a one-hot vector (highest wins if several are set)
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vend_coin_edge.sv
// rtl/vend_coin_edge.sv - coin rising-edge detector with dollar > quarter > dime priority
module vend_coin_edge (
  input  logic       clk,
  input  logic [2:0] coin_lvl,
  output logic [2:0] win,
  output logic [1:0] lose
);

  logic [2:0] hist;
  logic [2:0] edges;

  // History always tracks the levels, so a coin held through reset never looks like an edge
  always_ff @(posedge clk) begin
    hist <= coin_lvl;
  end

  always_comb begin
    edges = coin_lvl & ~hist;
    win   = 3'b000;
    if (edges[2])      win = 3'b100;
    else if (edges[1]) win = 3'b010;
    else if (edges[0]) win = 3'b001;
    lose = edges[1:0] & ~win[1:0];
  end

endmodule

// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parameterised vending controller: collect, vend handshake, greedy change payout
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int                         N_ITEMS = 4,
  parameter int                         MAX_QTY = 3,
  parameter int                         VAL_W   = 12,
  parameter logic [N_ITEMS*VAL_W-1:0]   PRICES  = {12'd120, 12'd100, 12'd80, 12'd50},
  parameter int                         TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ITEMS-1:0] item_sel,
  input  logic [MAX_QTY-1:0] qty_sel,
  input  logic               coin_dime,
  input  logic               coin_quarter,
  input  logic               coin_dollar,
  input  logic               cancel_n,
  input  logic               continue_n,
  input  logic               vend_ack,
  output logic [N_ITEMS-1:0] item_led,
  output logic [MAX_QTY-1:0] qty_out,
  output logic [VAL_W-1:0]   collected,
  output logic [VAL_W-1:0]   change_rem,
  output logic               vend_valid,
  output logic [2:0]         vend_item,
  output logic [2:0]         vend_qty,
  output logic               chg_dollar,
  output logic               chg_quarter,
  output logic               chg_dime,
  output logic               chg_nickel,
  output logic               busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  vend_state_t        state, nxt;
  logic [2:0]         win;
  logic [1:0]         lose;
  logic [VAL_W-1:0]   coin_val, coin_sum, price;
  logic [VAL_W+2:0]   cost;
  logic [2:0]         item_idx, qty_num;
  logic               timeout, vended, vended_d;
  logic [CNT_W-1:0]   idle_cnt, idle_cnt_d;
  logic [N_ITEMS-1:0] item_led_d;
  logic [MAX_QTY-1:0] qty_d;
  logic [VAL_W-1:0]   collected_d, change_rem_d;
  logic               vend_valid_d;
  logic [2:0]         vend_item_d, vend_qty_d;
  logic [3:0]         chg_d;

  function automatic logic [VAL_W-1:0] sat_add(input logic [VAL_W-1:0] a, input logic [VAL_W-1:0] b);
    logic [VAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[VAL_W] ? {VAL_W{1'b1}} : s[VAL_W-1:0];
  endfunction

  vend_coin_edge u_coin_edge (
    .clk      (clk),
    .coin_lvl ({coin_dollar, coin_quarter, coin_dime}),
    .win      (win),
    .lose     (lose)
  );

  always_comb begin
    coin_val = '0;
    if (win[2])      coin_val = VAL_W'(COIN_DOLLAR);
    else if (win[1]) coin_val = VAL_W'(COIN_QUARTER);
    else if (win[0]) coin_val = VAL_W'(COIN_DIME);
    coin_sum = sat_add(collected, coin_val);

    price = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (item_led[i]) price = PRICES[i*VAL_W +: VAL_W];
    end
    item_idx = onehot2idx(8'(item_led));
    qty_num  = onehot2idx(8'(qty_out)) + 3'd1;
    cost     = {3'b000, price} * {{VAL_W{1'b0}}, qty_num};
    timeout  = (TIMEOUT != 0) && (idle_cnt == CNT_W'(TIMEOUT));
  end

  always_comb begin
    nxt          = state;
    item_led_d   = item_led;
    qty_d        = qty_out;
    collected_d  = collected;
    change_rem_d = change_rem;
    vend_valid_d = vend_valid;
    vend_item_d  = vend_item;
    vend_qty_d   = vend_qty;
    vended_d     = vended;
    idle_cnt_d   = idle_cnt;
    chg_d        = 4'b0000;

    case (state)
      IDLE: begin
        idle_cnt_d = '0;
        if ($onehot(item_sel)) begin
          item_led_d = item_sel;
          nxt        = COLLECT;
        end
      end
      COLLECT: begin
        collected_d = coin_sum;
        chg_d[2]    = lose[1];
        chg_d[1]    = lose[0];
        // The affordability check sees last cycle's totals, so a coin arriving now joins the change
        if ({3'b000, collected} >= cost) begin
          change_rem_d = coin_sum - cost[VAL_W-1:0];
          vend_valid_d = 1'b1;
          vend_item_d  = item_idx;
          vend_qty_d   = qty_num;
          vended_d     = 1'b1;
          nxt          = VEND;
        end else if (!cancel_n || timeout) begin
          change_rem_d = coin_sum;
          nxt          = (coin_sum != '0) ? CHANGE : IDLE;
        end else begin
          idle_cnt_d = (|win) ? '0 : idle_cnt + 1'b1;
          if ($onehot(qty_sel) && (qty_sel != qty_out)) begin
            qty_d      = qty_sel;
            idle_cnt_d = '0;
          end
        end
      end
      VEND: begin
        change_rem_d = sat_add(change_rem, coin_val);
        chg_d[2]     = lose[1];
        chg_d[1]     = lose[0];
        if (vend_ack) begin
          vend_valid_d = 1'b0;
          nxt          = CHANGE;
        end
      end
      CHANGE: begin
        if (change_rem >= VAL_W'(COIN_DOLLAR)) begin
          chg_d[3]     = 1'b1;
          change_rem_d = change_rem - VAL_W'(COIN_DOLLAR);
        end else if (change_rem >= VAL_W'(COIN_QUARTER)) begin
          chg_d[2]     = 1'b1;
          change_rem_d = change_rem - VAL_W'(COIN_QUARTER);
        end else if (change_rem >= VAL_W'(COIN_DIME)) begin
          chg_d[1]     = 1'b1;
          change_rem_d = change_rem - VAL_W'(COIN_DIME);
        end else if (change_rem >= VAL_W'(COIN_NICKEL)) begin
          chg_d[0]     = 1'b1;
          change_rem_d = change_rem - VAL_W'(COIN_NICKEL);
        end else begin
          change_rem_d = '0;
          nxt          = vended ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!continue_n) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase

    // Every way back to IDLE presents the idle output values in the same cycle
    if (nxt == IDLE) begin
      item_led_d   = '0;
      qty_d        = MAX_QTY'(1);
      collected_d  = '0;
      change_rem_d = '0;
      vend_valid_d = 1'b0;
      vend_item_d  = '0;
      vend_qty_d   = '0;
      vended_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      item_led    <= '0;
      qty_out     <= MAX_QTY'(1);
      collected   <= '0;
      change_rem  <= '0;
      vend_valid  <= 1'b0;
      vend_item   <= '0;
      vend_qty    <= '0;
      vended      <= 1'b0;
      idle_cnt    <= '0;
      chg_dollar  <= 1'b0;
      chg_quarter <= 1'b0;
      chg_dime    <= 1'b0;
      chg_nickel  <= 1'b0;
    end else begin
      state       <= nxt;
      item_led    <= item_led_d;
      qty_out     <= qty_d;
      collected   <= collected_d;
      change_rem  <= change_rem_d;
      vend_valid  <= vend_valid_d;
      vend_item   <= vend_item_d;
      vend_qty    <= vend_qty_d;
      vended      <= vended_d;
      idle_cnt    <= idle_cnt_d;
      chg_dollar  <= chg_d[3];
      chg_quarter <= chg_d[2];
      chg_dime    <= chg_d[1];
      chg_nickel  <= chg_d[0];
    end
  end

  assign busy = (state != IDLE);

endmodule
